// File: rtl/ram_seq_ctrl.sv
// Sequence RAM controller for the drone memory game: appends recorded moves in IDLE
// and replays addresses 0..limit with a fixed hold time and an optional blank gap.
module ram_seq_ctrl #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_play,
  input  logic [3:0] limit,
  input  logic       rec_valid,
  input  logic [3:0] rec_data,
  input  logic       rec_clear,
  output logic       rec_ready,
  output logic [4:0] rec_count,
  output logic [3:0] ram_addr,
  output logic       ram_we,
  output logic [3:0] ram_data,
  input  logic [3:0] ram_q,
  output logic [3:0] move,
  output logic       move_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned HOLD_LAST = (HOLD_CYCLES > 1) ? HOLD_CYCLES - 1 : 0;
  localparam int unsigned GAP_LAST  = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;
  localparam int unsigned GAP_W     = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
  localparam bit          HAS_GAP   = (GAP_CYCLES > 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHOW  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [3:0]        idx;
  logic [3:0]        lim;
  logic [4:0]        wr_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              is_idle;
  logic              accept;

  // RAM port and handshake: combinational so a write lands on the handshake edge
  always_comb begin
    is_idle   = (state == ST_IDLE);
    rec_ready = is_idle & ~start_play & ~rec_clear & ~wr_ptr[4];
    accept    = rec_valid & rec_ready;
    ram_we    = accept & reset_n;
    ram_data  = rec_data;
    ram_addr  = is_idle ? wr_ptr[3:0] : idx;
    rec_count = wr_ptr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= 4'd0;
      lim        <= 4'd0;
      wr_ptr     <= 5'd0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      move       <= 4'd0;
      move_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_play) begin
            lim   <= limit;
            idx   <= 4'd0;
            busy  <= 1'b1;
            state <= ST_FETCH;
          end else if (rec_clear) begin
            wr_ptr <= 5'd0;
          end else if (accept) begin
            wr_ptr <= wr_ptr + 5'd1;
          end
        end
        ST_FETCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          move       <= ram_q;
          move_valid <= 1'b1;
          hold_cnt   <= '0;
          state      <= ST_SHOW;
        end
        ST_SHOW: begin
          if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
            move       <= 4'd0;
            move_valid <= 1'b0;
            if (HAS_GAP) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else if (idx == lim) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= ST_FETCH;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) begin
            if (idx == lim) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= ST_FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_DONE: begin
          move  <= 4'd0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          move       <= 4'd0;
          move_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Bench for ram_seq_ctrl: two instances (default timing, and hold=1/no gap) checked every
// cycle against a schedule model, plus hand-computed literal checkpoints.
module tb_ram_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start_play [2];
  logic [3:0] limit      [2];
  logic       rec_valid  [2];
  logic [3:0] rec_data   [2];
  logic       rec_clear  [2];
  logic       rec_ready  [2];
  logic [4:0] rec_count  [2];
  logic [3:0] ram_addr   [2];
  logic       ram_we     [2];
  logic [3:0] ram_data   [2];
  logic [3:0] ram_q      [2];
  logic [3:0] move       [2];
  logic       move_valid [2];
  logic       busy       [2];
  logic       done       [2];

  logic [3:0] ram [2][16];
  logic       pl_we   = 1'b0;
  int         pl_k    = 0;
  logic [3:0] pl_addr = 4'd0;
  logic [3:0] pl_data = 4'd0;

  int total = 0;
  int bad   = 0;
  int now   = 0;

  // model: mv = model live, mp = playing, mt = cycle index since start, ml = limit, mw = write count
  bit         mv [2] = '{0, 0};
  bit         mp [2] = '{0, 0};
  int         mt [2] = '{0, 0};
  int         ml [2] = '{0, 0};
  int         mw [2] = '{0, 0};
  logic [3:0] mm [2][16];

  ram_seq_ctrl #(.HOLD_CYCLES(8), .GAP_CYCLES(2)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start_play(start_play[0]), .limit(limit[0]),
    .rec_valid(rec_valid[0]), .rec_data(rec_data[0]), .rec_clear(rec_clear[0]),
    .rec_ready(rec_ready[0]), .rec_count(rec_count[0]), .ram_addr(ram_addr[0]),
    .ram_we(ram_we[0]), .ram_data(ram_data[0]), .ram_q(ram_q[0]), .move(move[0]),
    .move_valid(move_valid[0]), .busy(busy[0]), .done(done[0])
  );

  ram_seq_ctrl #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start_play(start_play[1]), .limit(limit[1]),
    .rec_valid(rec_valid[1]), .rec_data(rec_data[1]), .rec_clear(rec_clear[1]),
    .rec_ready(rec_ready[1]), .rec_count(rec_count[1]), .ram_addr(ram_addr[1]),
    .ram_we(ram_we[1]), .ram_data(ram_data[1]), .ram_q(ram_q[1]), .move(move[1]),
    .move_valid(move_valid[1]), .busy(busy[1]), .done(done[1])
  );

  // 16x4 synchronous RAMs with a bench-side preload port
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pl_we && pl_k == k) ram[k][pl_addr] <= pl_data;
      else if (ram_we[k]) ram[k][ram_addr[k]] <= ram_data[k];
      ram_q[k] <= ram[k][ram_addr[k]];
    end
  end

  function automatic int hold_of(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int done_cycle(input int k);
    return 1 + (ml[k] + 1) * (2 + hold_of(k) + gap_of(k));
  endfunction

  task automatic chk(input string name, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %0d expected %0d (cycle %0d, time %0t)",
               name, inst, act, exp, now, $time);
    end
  endtask

  // model update on the sampling edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pl_we && pl_k == k) mm[k][pl_addr] = pl_data;
      if (!reset_n) begin
        mv[k] = 1'b1;
        mp[k] = 1'b0;
        mw[k] = 0;
      end else if (mp[k]) begin
        if (mt[k] == done_cycle(k)) mp[k] = 1'b0;
        else mt[k] = mt[k] + 1;
      end else if (start_play[k]) begin
        mp[k] = 1'b1;
        mt[k] = 1;
        ml[k] = int'(limit[k]);
      end else if (rec_clear[k]) begin
        mw[k] = 0;
      end else if (rec_valid[k] && mw[k] < 16) begin
        mm[k][mw[k] % 16] = rec_data[k];
        mw[k] = mw[k] + 1;
      end
    end
  end

  // compare process on the falling edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int p, d, e, r;
      bit sh;
      bit rdy;
      if (mv[k]) begin
        if (!reset_n) begin
          chk("ram_we_in_reset", k, int'(ram_we[k]), 0);
        end else if (mp[k]) begin
          p  = 2 + hold_of(k) + gap_of(k);
          d  = done_cycle(k);
          e  = (mt[k] - 1) / p;
          r  = (mt[k] - 1) % p;
          sh = (mt[k] < d) && (r >= 2) && (r < 2 + hold_of(k));
          chk("busy", k, int'(busy[k]), 1);
          chk("ram_we_busy", k, int'(ram_we[k]), 0);
          chk("rec_ready_busy", k, int'(rec_ready[k]), 0);
          chk("rec_count_busy", k, int'(rec_count[k]), mw[k]);
          chk("done", k, int'(done[k]), (mt[k] == d) ? 1 : 0);
          chk("move_valid", k, int'(move_valid[k]), sh ? 1 : 0);
          chk("move", k, int'(move[k]), sh ? int'(mm[k][e % 16]) : 0);
          if (mt[k] < d && r == 0) chk("fetch_addr", k, int'(ram_addr[k]), e);
        end else begin
          rdy = !start_play[k] && !rec_clear[k] && mw[k] < 16;
          chk("rec_ready", k, int'(rec_ready[k]), rdy ? 1 : 0);
          chk("ram_we", k, int'(ram_we[k]), (rdy && rec_valid[k]) ? 1 : 0);
          chk("ram_addr_idle", k, int'(ram_addr[k]), mw[k] % 16);
          chk("rec_count", k, int'(rec_count[k]), mw[k]);
          chk("busy_idle", k, int'(busy[k]), 0);
          chk("move_idle", k, int'(move[k]), 0);
          chk("move_valid_idle", k, int'(move_valid[k]), 0);
          chk("done_idle", k, int'(done[k]), 0);
          if (ram_we[k]) chk("ram_data", k, int'(ram_data[k]), int'(rec_data[k]));
        end
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      now++;
    end
  endtask

  task automatic adv_to(input int c);
    while (now < c) adv(1);
  endtask

  task automatic preload(input int k, input int a, input logic [3:0] dv);
    pl_k    = k;
    pl_addr = 4'(a);
    pl_data = dv;
    pl_we   = 1'b1;
    adv(1);
    pl_we   = 1'b0;
  endtask

  task automatic play(input int k, input logic [3:0] lv, output int base);
    start_play[k] = 1'b1;
    limit[k]      = lv;
    base          = now;
    adv(1);
    start_play[k] = 1'b0;
  endtask

  initial begin
    int b;
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_play[k] = 1'b0;
      limit[k]      = 4'd0;
      rec_valid[k]  = 1'b0;
      rec_data[k]   = 4'd0;
      rec_clear[k]  = 1'b0;
    end
    adv(3);
    chk("reset_busy", 0, int'(busy[0]), 0);
    chk("reset_count", 0, int'(rec_count[0]), 0);
    reset_n = 1'b1;
    adv(1);

    // 1: preloaded RAM, limit 3
    preload(0, 0, 4'b0000);
    preload(0, 1, 4'b0010);
    preload(0, 2, 4'b0100);
    preload(0, 3, 4'b1000);
    play(0, 4'd3, b);
    adv_to(b + 3);  chk("t1_mv3", 0, int'(move_valid[0]), 1);
                    chk("t1_mov3", 0, int'(move[0]), 0);
    adv_to(b + 11); chk("t1_gap11", 0, int'(move_valid[0]), 0);
    adv_to(b + 15); chk("t1_mov15", 0, int'(move[0]), 2);
    adv_to(b + 27); chk("t1_mov27", 0, int'(move[0]), 4);
    adv_to(b + 46); chk("t1_mov46", 0, int'(move[0]), 8);
    adv_to(b + 48); chk("t1_done48", 0, int'(done[0]), 0);
    adv_to(b + 49); chk("t1_done49", 0, int'(done[0]), 1);
                    chk("t1_busy49", 0, int'(busy[0]), 1);
    adv_to(b + 50); chk("t1_busy50", 0, int'(busy[0]), 0);

    // 2: clear, 16 writes, rejected 17th offer, full playback
    rec_clear[0] = 1'b1;
    adv(1);
    rec_clear[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rec_valid[0] = 1'b1;
      rec_data[0]  = 4'(1 << (i % 4));
      adv(1);
    end
    rec_data[0] = 4'hF;
    #1;
    chk("t2_count16", 0, int'(rec_count[0]), 16);
    chk("t2_ready16", 0, int'(rec_ready[0]), 0);
    chk("t2_we17", 0, int'(ram_we[0]), 0);
    adv(1);
    rec_valid[0] = 1'b0;
    play(0, 4'd15, b);
    adv_to(b + 3);   chk("t2_mov3", 0, int'(move[0]), 1);
    adv_to(b + 15);  chk("t2_mov15", 0, int'(move[0]), 2);
    adv_to(b + 183); chk("t2_mov183", 0, int'(move[0]), 8);
    adv_to(b + 193); chk("t2_done193", 0, int'(done[0]), 1);
    adv(1);

    // 3: limit 0
    play(0, 4'd0, b);
    adv_to(b + 10); chk("t3_mov10", 0, int'(move[0]), 1);
    adv_to(b + 11); chk("t3_mv11", 0, int'(move_valid[0]), 0);
    adv_to(b + 13); chk("t3_done13", 0, int'(done[0]), 1);
                    chk("t3_idx13", 0, int'(ram_addr[0]), 0);
    adv_to(b + 14); chk("t3_busy14", 0, int'(busy[0]), 0);

    // 4: reset during playback, then replay
    play(0, 4'd15, b);
    adv_to(b + 20);
    reset_n = 1'b0;
    adv(1);
    chk("t4_move", 0, int'(move[0]), 0);
    chk("t4_mv", 0, int'(move_valid[0]), 0);
    chk("t4_busy", 0, int'(busy[0]), 0);
    chk("t4_count", 0, int'(rec_count[0]), 0);
    reset_n = 1'b1;
    adv(2);
    play(0, 4'd3, b);
    adv_to(b + 15); chk("t4_replay15", 0, int'(move[0]), 2);
    adv_to(b + 50);

    // 5: start_play and rec_valid together, then offers while busy
    start_play[0] = 1'b1;
    limit[0]      = 4'd1;
    rec_valid[0]  = 1'b1;
    rec_data[0]   = 4'd5;
    b             = now;
    #1;
    chk("t5_ready", 0, int'(rec_ready[0]), 0);
    chk("t5_we", 0, int'(ram_we[0]), 0);
    adv(1);
    start_play[0] = 1'b0;
    adv(6);
    rec_valid[0] = 1'b0;
    adv_to(b + 25); chk("t5_done25", 0, int'(done[0]), 1);
    adv(2);
    chk("t5_count", 0, int'(rec_count[0]), 0);

    // 6: hold 1, no gap, limit 2
    preload(1, 0, 4'b0001);
    preload(1, 1, 4'b0010);
    preload(1, 2, 4'b0100);
    play(1, 4'd2, b);
    adv_to(b + 3);  chk("t6_mv3", 1, int'(move_valid[1]), 1);
    adv_to(b + 4);  chk("t6_mv4", 1, int'(move_valid[1]), 0);
    adv_to(b + 6);  chk("t6_mov6", 1, int'(move[1]), 2);
    adv_to(b + 9);  chk("t6_mov9", 1, int'(move[1]), 4);
    adv_to(b + 10); chk("t6_done10", 1, int'(done[1]), 1);
    adv(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
- Sequencer for the 16x4 synchronous sequence RAM used by the drone memory game.
- In PLAY, it steps through RAM addresses 0..limit and presents each stored 4-bit one-hot move for a fixed hold time, followed by a gap.
- In IDLE, it accepts recorded moves over a valid/ready handshake and appends them to the RAM.
- It is the only driver of the RAM's addr/we/data ports and sits between the game FSM and the RAM.

Parameters:
- HOLD_CYCLES, 8: number of cycles each move is shown; must be >= 1.
- GAP_CYCLES, 2: number of blank cycles after each move; 0 means no gap.

Ports:
- clk  in  1  system clock; all logic acts on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- start_play  in  1  request playback; sampled only in IDLE.
- limit  in  4  last address to play, inclusive; captured when start_play is accepted.
- rec_valid  in  1  a recorded move is offered.
- rec_data  in  4  the recorded move.
- rec_clear  in  1  in IDLE, resets the write pointer to 0.
- rec_ready  out  1  controller can accept a recorded move this cycle.
- rec_count  out  5  number of moves recorded, 0..16.
- ram_addr  out  4  RAM address.
- ram_we  out  1  RAM write enable.
- ram_data  out  4  RAM write data.
- ram_q  in  4  RAM read data; valid one cycle after ram_addr is applied.
- move  out  4  move currently shown; 0 when not showing.
- move_valid  out  1  high during SHOW.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when playback completes.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state IDLE, idx 0, wr_ptr 0, move 0, move_valid 0, done 0, hold/gap counters 0.
  - ram_we is forced to 0 combinationally while reset_n is low.
  - RAM contents are not cleared.
  - Reset asserted mid-playback aborts the playback with no done pulse.
- States: IDLE, FETCH, WAIT, SHOW, GAP, DONE.
- IDLE:
  - ram_addr = wr_ptr[3:0].
  - rec_ready = (state==IDLE) & ~start_play & ~rec_clear & (rec_count<16).
  - ram_we = rec_valid & rec_ready; ram_data = rec_data. These are combinational, so the write lands at the same edge the handshake completes.
  - On a completed handshake, wr_ptr increments. rec_count = wr_ptr, saturating at 16; at 16, rec_ready is 0 and offers are ignored.
  - rec_clear: wr_ptr <= 0. It has priority over rec_valid and is ignored outside IDLE.
  - start_play: latch limit, idx <= 0, go to FETCH. It has priority over rec_valid in the same cycle (no write occurs).
  - start_play outside IDLE is ignored.
- FETCH (1 cycle): ram_addr = idx, ram_we = 0. Go to WAIT.
- WAIT (1 cycle): ram_q is valid; move <= ram_q. Go to SHOW.
- SHOW (HOLD_CYCLES cycles): move_valid = 1 and move is held.
  - Exit to GAP if GAP_CYCLES > 0.
  - Otherwise exit to FETCH with idx+1 if idx != limit, or to DONE if idx == limit.
- GAP (GAP_CYCLES cycles): move = 0, move_valid = 0. Then go to FETCH (idx <= idx+1) or to DONE if idx == limit.
  - idx never wraps past 15 because limit <= 15.
- DONE (1 cycle): done = 1, move = 0. Go to IDLE.
- Timing: start_play sampled at cycle 0 means FETCH in cycle 1 and the first move_valid in cycle 3.
  - Each entry takes 2 + HOLD_CYCLES + GAP_CYCLES cycles.
  - done is asserted in cycle 1 + (limit+1) × (2+HOLD_CYCLES+GAP_CYCLES).
- ram_addr outside IDLE equals idx; ram_we is 0 outside IDLE.
- Playback reads whatever the RAM holds, independent of rec_count.

Test Plan:
1. RAM preloaded {0000,0010,0100,1000,...}, limit=3, default parameters, start_play pulse at cycle 0 -> move=0000 in cycles 3-10, 0010 in 15-22, 0100 in 27-34, 1000 in 39-46; move_valid=0 in the gaps; done high only in cycle 49; busy high in cycles 1-49.
2. rec_clear, then 16 handshakes with rec_data=0001,0010,0100,1000 repeated -> writes at addresses 0..15, rec_count=16, rec_ready=0, a 17th rec_valid produces no write. Then play with limit=15 -> moves read back in the same order, done at cycle 193.
3. limit=0 -> exactly one move shown (cycles 3-10), done at cycle 13; idx is not incremented.
4. reset_n low at cycle 20 of a playback -> at the next edge move=0, move_valid=0, busy=0, done never pulses, rec_count=0, RAM data intact on the next play.
5. start_play and rec_valid both high in IDLE -> rec_ready=0, ram_we=0, playback starts; rec_valid during busy -> no write.
6. GAP_CYCLES=0, HOLD_CYCLES=1, limit=2 -> move_valid high in cycles 3, 6 and 9; done at cycle 10.
